// File: rtl/hs4_resp_fifo_if.sv
// Bundle of the send/ack handshake and the consumer pop port for hs4_resp_fifo.
// master = initiator/consumer side, slave = the responder FIFO.
interface hs4_resp_fifo_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic              send;
    logic [DATA_W-1:0] dados;
    logic              ack;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic [1:0]        estado;

    modport master (
        output send, dados, rd_en,
        input  ack, rd_data, empty, full, count, estado
    );

    modport slave (
        input  send, dados, rd_en,
        output ack, rd_data, empty, full, count, estado
    );
endinterface

// File: rtl/hs4_resp_fifo.sv
// Responder end of the 4-phase send/ack handshake: captures each offered word into a FIFO,
// withholds ack while full. Optional macro HS4_SYNC2_EN puts a 2-flop synchronizer on send.
module hs4_resp_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic clk,
    input  logic rst,
    hs4_resp_fifo_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STALL   = 2'b01,
        ACK_HI  = 2'b10,
        RECOVER = 2'b11
    } state_e;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    state_e            state_q;
    logic              ack_q;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W-1:0] rptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              full_q;
    logic              empty_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic send_s;
    logic push;
    logic pop;

    // stage p0/p1: optional send synchronizer
`ifdef HS4_SYNC2_EN
    logic send_p0;
    logic send_p1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            send_p0 <= 1'b0;
            send_p1 <= 1'b0;
        end else begin
            send_p0 <= bus.send;
            send_p1 <= send_p0;
        end
    end

    assign send_s = send_p1;
`else
    assign send_s = bus.send;
`endif

    // A word is taken only from IDLE or STALL, so a held send can never push twice.
    assign push = send_s && !full_q && ((state_q == IDLE) || (state_q == STALL));
    assign pop  = bus.rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (send_s) begin
                        if (!full_q) begin
                            state_q <= ACK_HI;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= STALL;
                        end
                    end
                end
                STALL: begin
                    // A send dropped while stalled is a protocol violation: abandon the offer.
                    if (!send_s) begin
                        state_q <= IDLE;
                    end else if (!full_q) begin
                        state_q <= ACK_HI;
                        ack_q   <= 1'b1;
                    end
                end
                ACK_HI: begin
                    if (!send_s) begin
                        state_q <= RECOVER;
                        ack_q   <= 1'b0;
                    end
                end
                RECOVER: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // stage p0: pointers, occupancy and the registered read port
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_data_q <= mem_q[rptr_q];
                rptr_q    <= rptr_q + PTR_ONE;
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset; contents are dead once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.dados;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.rd_data = rd_data_q;
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.count   = count_q;
    assign bus.estado  = state_q;

endmodule

// File: tb/tb_hs4_resp_fifo.sv
// Scoreboard bench for hs4_resp_fifo: directed handshakes plus a randomized initiator/consumer,
// checked every cycle against a queue-based protocol model.
module tb_hs4_resp_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct {
        logic              ack;
        logic [1:0]        st;
        int                cnt;
        logic              emp;
        logic              ful;
        logic [DATA_W-1:0] rd;
    } exp_t;

    logic clk;
    logic rst;

    hs4_resp_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hs4_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t expq[$];

    // Reference model: stored words, plus protocol-level flags for the responder side.
    logic [DATA_W-1:0] mq[$];
    logic              m_ack   = 1'b0;
    logic              m_dead  = 1'b0;
    logic              m_stall = 1'b0;
    logic [DATA_W-1:0] m_rd    = '0;
    logic [1:0]        sh      = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs and predict the outputs after the following rising edge.
    task automatic step(input logic rst_v, input logic send_v, input logic [DATA_W-1:0] d_v,
                        input logic rd_v);
        logic send_s;
        int   sz;
        logic acc;
        logic n_ack, n_dead, n_stall;
        exp_t e;
        @(negedge clk);
        rst       = rst_v;
        bus.send  = send_v;
        bus.dados = d_v;
        bus.rd_en = rd_v;
        if (!rst_v) begin
            mq.delete();
            m_ack   = 1'b0;
            m_dead  = 1'b0;
            m_stall = 1'b0;
            m_rd    = '0;
            sh      = 2'b00;
        end else begin
`ifdef HS4_SYNC2_EN
            send_s = sh[1];
`else
            send_s = send_v;
`endif
            sh      = {sh[0], send_v};
            sz      = mq.size();
            acc     = 1'b0;
            n_ack   = 1'b0;
            n_dead  = 1'b0;
            n_stall = 1'b0;
            if (m_dead) begin
                n_ack = 1'b0;
            end else if (m_ack) begin
                if (send_s) n_ack = 1'b1;
                else        n_dead = 1'b1;
            end else if (send_s && (sz < DEPTH)) begin
                acc   = 1'b1;
                n_ack = 1'b1;
            end else if (send_s) begin
                n_stall = 1'b1;
            end
            if (rd_v && (sz > 0)) m_rd = mq.pop_front();
            if (acc) mq.push_back(d_v);
            m_ack   = n_ack;
            m_dead  = n_dead;
            m_stall = n_stall;
        end
        e.ack = m_ack;
        e.st  = m_ack ? 2'd2 : (m_dead ? 2'd3 : (m_stall ? 2'd1 : 2'd0));
        e.cnt = mq.size();
        e.emp = (mq.size() == 0);
        e.ful = (mq.size() == DEPTH);
        e.rd  = m_rd;
        expq.push_back(e);
    endtask

    // Complete one handshake for word d, waiting on ack with a bounded budget.
    task automatic hs(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        step(1'b1, 1'b1, d, 1'b0);
        while (n < 30) begin
            @(posedge clk); #1;
            if (bus.ack === 1'b1) break;
            step(1'b1, 1'b1, d, 1'b0);
            n++;
        end
        if (n >= 30) begin
            n_chk++; n_fail++;
            $display("FAIL hs_ack_rise_timeout: ack=%b, expected 1", bus.ack);
        end
        n = 0;
        step(1'b1, 1'b0, d, 1'b0);
        while (n < 30) begin
            @(posedge clk); #1;
            if (bus.ack === 1'b0) break;
            step(1'b1, 1'b0, d, 1'b0);
            n++;
        end
        if (n >= 30) begin
            n_chk++; n_fail++;
            $display("FAIL hs_ack_fall_timeout: ack=%b, expected 0", bus.ack);
        end
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    // Monitor: one expectation per rising edge that followed a driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("ack",     32'(bus.ack),     32'(e.ack));
                chk("estado",  32'(bus.estado),  32'(e.st));
                chk("count",   32'(bus.count),   32'(e.cnt));
                chk("empty",   32'(bus.empty),   32'(e.emp));
                chk("full",    32'(bus.full),    32'(e.ful));
                chk("rd_data", 32'(bus.rd_data), 32'(e.rd));
            end
        end
    end

    initial begin
        int          ini;
        logic        s;
        logic [3:0]  d;
        logic        rd;
        logic        rst_v;
        int          n;

        rst       = 1'b0;
        bus.send  = 1'b0;
        bus.dados = '0;
        bus.rd_en = 1'b0;

        // Reset held with send asserted
        step(1'b0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b0);

        // Single word then pop
        hs(4'h7);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Fill, backpressure, release by a pop, drain in order
        for (int i = 1; i <= 4; i++) hs(4'(i));
        step(1'b1, 1'b1, 4'h5, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b1);
        n = 0;
        while (n < 30) begin
            step(1'b1, 1'b1, 4'h5, 1'b0);
            @(posedge clk); #1;
            if (bus.ack === 1'b1) break;
            n++;
        end
        if (n >= 30) begin
            n_chk++; n_fail++;
            $display("FAIL stall_release_timeout: ack=%b, expected 1", bus.ack);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'h0, 1'b1);

        // Simultaneous push and pop with two words stored
        hs(4'h8);
        hs(4'h9);
        step(1'b1, 1'b1, 4'hB, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'hB, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 1'b1);

        // Pop on empty holds rd_data
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);

        // Reset mid-handshake with three words stored, then a fresh word
        hs(4'h1);
        hs(4'h2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h3, 1'b0);
        step(1'b0, 1'b1, 4'h3, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        hs(4'hA);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b0);

        // Randomized initiator and consumer, with rare resets
        ini = 0;
        s   = 1'b0;
        d   = '0;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            case (ini)
                0: if ($urandom_range(0, 1) == 1) begin
                       s   = 1'b1;
                       d   = 4'($urandom);
                       ini = 1;
                   end
                1: if (bus.ack === 1'b1) begin
                       ini = 2;
                       d   = 4'($urandom);
                   end
                2: begin
                       d = 4'($urandom);
                       if ($urandom_range(0, 2) == 0) begin
                           s   = 1'b0;
                           ini = 3;
                       end
                   end
                default: if (bus.ack === 1'b0) ini = 0;
            endcase
            if (((c / 200) % 2) == 1) rd = ($urandom_range(0, 7) == 0);
            else                      rd = ($urandom_range(0, 1) == 1);
            rst_v = ($urandom_range(0, 499) != 0);
            if (!rst_v) begin
                s   = 1'b0;
                ini = 0;
            end
            step(rst_v, s, d, rd);
        end

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
